// File: rtl/pc_sequencer.sv
// Microcode address sequencer: next/jump/branch/call/return/wait/halt with a
// small hardware return-address stack and sticky stack-error reporting.
module pc_sequencer #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               run,
  input  logic [2:0]                         op,
  input  logic [ADDR_W-1:0]                  target,
  input  logic                               zero,
  input  logic                               ext_ready,
  output logic [ADDR_W-1:0]                  addr,
  output logic                               fetch_valid,
  output logic                               halted,
  output logic                               stack_err,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp
);

  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_JZ   = 3'd2;
  localparam logic [2:0] OP_JNZ  = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;
  localparam logic [2:0] OP_WAIT = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [ADDR_W-1:0] pc1;
  logic              stack_full;
  logic              stack_empty;
  logic              push;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;

  assign pc1         = addr + ADDR_W'(1);
  assign fetch_valid = (state == S_RUN) && run;
  assign halted      = (state == S_HALT);
  assign stack_full  = (sp >= SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign push_idx    = IDX_W'(sp);
  assign pop_idx     = IDX_W'(sp - SP_W'(1));
  assign push        = !rst && !start && fetch_valid && (op == OP_CALL) && !stack_full;

  // Return-address storage; contents need no reset since sp gates every read.
  always_ff @(posedge clk) begin
    if (push) stack[push_idx] <= pc1;
  end

  // Sequencer state, address, stack pointer and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      sp        <= '0;
      stack_err <= 1'b0;
    end else if (start) begin
      state     <= S_RUN;
      addr      <= '0;
      sp        <= '0;
      stack_err <= 1'b0;
    end else if (fetch_valid) begin
      case (op)
        OP_NEXT: addr <= pc1;
        OP_JMP:  addr <= target;
        OP_JZ:   addr <= zero ? target : pc1;
        OP_JNZ:  addr <= zero ? pc1 : target;
        OP_CALL: begin
          if (!stack_full) begin
            sp   <= sp + SP_W'(1);
            addr <= target;
          end else begin
            stack_err <= 1'b1;
            state     <= S_HALT;
          end
        end
        OP_RET: begin
          if (!stack_empty) begin
            sp   <= sp - SP_W'(1);
            addr <= stack[pop_idx];
          end else begin
            stack_err <= 1'b1;
            state     <= S_HALT;
          end
        end
        OP_HALT: state <= S_HALT;
        OP_WAIT: if (ext_ready) addr <= pc1;
      endcase
    end
  end

endmodule
